// File: rtl/cap_switch_sequencer.sv
// Frequency-tracking sequencer for the series/parallel capacitor banks.
// Measures the sync period over N_SYNC rising edges, hands the window count to the two
// lut_n instances, and applies their bank states with a break-before-make interval.
module cap_switch_sequencer #(
    parameter int unsigned N_SYNC    = 50,
    parameter int unsigned CNT_W     = 14,
    parameter int unsigned STATE_W   = 7,
    parameter int unsigned N_MIN     = 666,
    parameter int unsigned N_MAX     = 5000,
    parameter int unsigned LUT_LAT   = 2,
    parameter int unsigned DEAD_CLKS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sync_in,
    input  logic [STATE_W-1:0] state_ser_lut,
    input  logic [STATE_W-1:0] state_par_lut,
    output logic [CNT_W-1:0]   n_clk_cnts,
    output logic [STATE_W-1:0] state_ser,
    output logic [STATE_W-1:0] state_par,
    output logic               locked,
    output logic               update_strobe,
    output logic               overrun
);

    localparam int unsigned EDGE_W = $clog2(N_SYNC + 1);
    localparam int unsigned LAT_W  = $clog2(LUT_LAT + 1);
    localparam int unsigned DEAD_W = $clog2(DEAD_CLKS + 1);

    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(N_SYNC - 1);
    localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(N_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]    WIN_MIN   = (CNT_W + 1)'(N_MIN);
    localparam logic [CNT_W:0]    WIN_MAX   = (CNT_W + 1)'(N_MAX);
    localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LUT_LAT - 1);
    localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CLKS - 1);

    typedef enum logic {MeasIdle, MeasRun} meas_e;
    typedef enum logic [2:0] {UpdIdle, UpdLookup, UpdCompare, UpdBreak, UpdApply} upd_e;

    logic              sync_meta_q, sync_q, sync_prev_q, edge_p_q;
    meas_e             meas_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [EDGE_W-1:0] edges_q;
    logic              req_q;
    logic [CNT_W:0]    win_w;

    upd_e              upd_q;
    logic [LAT_W-1:0]  lat_q;
    logic [DEAD_W-1:0] dead_q;
    logic [STATE_W-1:0] new_ser_q, new_par_q;

    // Window length: cycles between the start and end pulses.
    assign win_w = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // Two-flop synchronizer plus registered rising-edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
            edge_p_q    <= 1'b0;
        end else begin
            sync_meta_q <= sync_in;
            sync_q      <= sync_meta_q;
            sync_prev_q <= sync_q;
            edge_p_q    <= sync_q & ~sync_prev_q;
        end
    end

    // Measurement FSM: counts cycles over N_SYNC edge pulses and publishes valid windows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meas_q     <= MeasIdle;
            cnt_q      <= '0;
            edges_q    <= '0;
            req_q      <= 1'b0;
            n_clk_cnts <= '0;
            locked     <= 1'b0;
        end else begin
            req_q <= 1'b0;
            case (meas_q)
                MeasIdle: begin
                    if (edge_p_q) begin
                        cnt_q   <= '0;
                        edges_q <= '0;
                        meas_q  <= MeasRun;
                    end
                end
                MeasRun: begin
                    if (cnt_q >= CNT_LIMIT) begin
                        // Sync lost: drop lock, banks keep their last states.
                        locked <= 1'b0;
                        meas_q <= MeasIdle;
                    end else begin
                        // Saturate rather than wrap.
                        if (cnt_q != CNT_SAT) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                        if (edge_p_q) begin
                            if (edges_q == EDGE_LAST) begin
                                // End pulse doubles as the start of the next window.
                                cnt_q   <= '0;
                                edges_q <= '0;
                                if (win_w >= WIN_MIN && win_w <= WIN_MAX) begin
                                    n_clk_cnts <= win_w[CNT_W-1:0];
                                    locked     <= 1'b1;
                                    req_q      <= 1'b1;
                                end else begin
                                    locked <= 1'b0;
                                end
                            end else begin
                                edges_q <= edges_q + EDGE_ONE;
                            end
                        end
                    end
                end
                default: meas_q <= MeasIdle;
            endcase
        end
    end

    // Update FSM: wait for the LUTs, then break-before-make onto the new bank states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_q         <= UpdIdle;
            lat_q         <= '0;
            dead_q        <= '0;
            new_ser_q     <= '0;
            new_par_q     <= '0;
            state_ser     <= '0;
            state_par     <= '0;
            update_strobe <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (req_q && upd_q != UpdIdle) begin
                overrun <= 1'b1;
            end
            case (upd_q)
                UpdIdle: begin
                    if (req_q) begin
                        // req arrives one cycle after n_clk_cnts changed.
                        lat_q <= LAT_ONE;
                        upd_q <= (LUT_LAT <= 1) ? UpdCompare : UpdLookup;
                    end
                end
                UpdLookup: begin
                    if (lat_q >= LAT_LAST) begin
                        upd_q <= UpdCompare;
                    end else begin
                        lat_q <= lat_q + LAT_ONE;
                    end
                end
                UpdCompare: begin
                    if (state_ser_lut == state_ser && state_par_lut == state_par) begin
                        upd_q <= UpdIdle;
                    end else begin
                        // Only bits that stay on remain on during the break.
                        new_ser_q <= state_ser_lut;
                        new_par_q <= state_par_lut;
                        state_ser <= state_ser & state_ser_lut;
                        state_par <= state_par & state_par_lut;
                        dead_q    <= '0;
                        upd_q     <= UpdBreak;
                    end
                end
                UpdBreak: begin
                    if (dead_q == DEAD_LAST) begin
                        state_ser     <= new_ser_q;
                        state_par     <= new_par_q;
                        update_strobe <= 1'b1;
                        upd_q         <= UpdApply;
                    end else begin
                        dead_q <= dead_q + DEAD_ONE;
                    end
                end
                UpdApply: begin
                    update_strobe <= 1'b0;
                    upd_q         <= UpdIdle;
                end
                default: upd_q <= UpdIdle;
            endcase
        end
    end

endmodule

// File: doc/cap_switch_sequencer.md
Name: cap_switch_sequencer

Overview:
- Closes the frequency-tracking loop around the two lut_n instances: series bank and parallel bank.
- Measures the period of the synchronized drive-frequency sync input over N_SYNC rising edges. Presents the result as n_clk_cnts to both LUTs.
- Sequences the capacitor-bank update using break-before-make switching, so a bank bit never changes directly from one configuration to another.
- Sits between the sync input conditioning and the series/parallel switch drivers.

Parameters:
- N_SYNC, 50, sync rising edges per measurement window.
- CNT_W, 14, width of n_clk_cnts and the period counter.
- STATE_W, 7, width of each bank state word.
- N_MIN, 666, minimum valid window count (300 kHz at 4 MHz clk).
- N_MAX, 5000, maximum valid window count (40 kHz at 4 MHz clk).
- LUT_LAT, 2, clk cycles from an n_clk_cnts change to a valid LUT output.
- DEAD_CLKS, 8, break interval in clk cycles.

Ports:
- clk  in  1  system clock (4 MHz).
- reset  in  1  asynchronous, active-high reset.
- sync_in  in  1  asynchronous sync square wave.
- state_ser_lut  in  STATE_W  series lut_n output.
- state_par_lut  in  STATE_W  parallel lut_n output.
- n_clk_cnts  out  CNT_W  measured window count, driven to both lut_n instances.
- state_ser  out  STATE_W  series bank switch drive.
- state_par  out  STATE_W  parallel bank switch drive.
- locked  out  1  last window valid and in range.
- update_strobe  out  1  one-cycle pulse when new states are applied.
- overrun  out  1  sticky flag: a window completed while an update was still in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0.
  - FSM goes to IDLE; counters clear; synchronizer flops clear.
  - Reset asserted mid-update forces both banks off immediately.
- Sync conditioning:
  - Two-flop synchronizer, then rising-edge detect.
  - The result is a one-cycle pulse, edge_p, 3 cycles after the sync_in rise.
- Measurement FSM (state meas: IDLE, RUN):
  - IDLE: on edge_p, set cnt=0 and edges=0, go to RUN.
  - RUN: each cycle, cnt = cnt+1. On edge_p, edges = edges+1.
  - Window end: on the edge_p where edges reaches N_SYNC.
    - Window value W = cnt+1, i.e. cycles between the start and end pulses.
    - The end pulse is also the start of the next window: cnt=0, edges=0, stay in RUN.
  - Range check on W:
    - N_MIN <= W <= N_MAX: register n_clk_cnts=W on the next cycle, set locked=1, raise req to the update FSM.
    - W < N_MIN: n_clk_cnts holds, locked=0, no req.
  - Timeout: if cnt reaches N_MAX+1 in RUN, set locked=0, n_clk_cnts holds, go to IDLE. Bank outputs are held.
  - cnt saturates and never wraps.
- Update FSM (states UIDLE, LOOKUP, COMPARE, BREAK, APPLY):
  - UIDLE: on req, go to LOOKUP.
  - LOOKUP: wait LUT_LAT cycles after n_clk_cnts changed, then go to COMPARE.
  - COMPARE: sample both LUT inputs.
    - If both equal the current outputs, return to UIDLE. No strobe, no break.
    - Otherwise go to BREAK.
  - BREAK: state_ser = old & new_ser and state_par = old & new_par.
    - Only bits that stay on remain on; bits that are turning on stay off.
    - Held for exactly DEAD_CLKS cycles.
  - APPLY: state_ser = new_ser and state_par = new_par.
    - update_strobe=1 for this single cycle, then go to UIDLE.
- Update latency: with an edge_p window end at cycle t, n_clk_cnts is valid at t+1 and COMPARE occurs at t+1+LUT_LAT.
  - If no break bits are needed (new is a superset of old), BREAK still lasts DEAD_CLKS cycles. Timing is uniform.
  - The new states appear at t+2+LUT_LAT+DEAD_CLKS.
- Overrun: a req arriving while the update FSM is not in UIDLE is dropped and sets overrun.
  - This cannot occur for valid parameters; it is a parameter-misconfiguration check.
- Lost lock: existing bank states are never cleared on loss of lock; only reset clears them.
- Measurement continues independently during BREAK and APPLY.

Test Plan:
- Reset mid-BREAK: assert reset during BREAK -> state_ser, state_par and locked are 0 within the same cycle (asynchronous); after release, FSM is in IDLE.
- Steady sync, period 20 clks: -> n_clk_cnts=1000 after the 51st edge; locked=1; LUT output change applied with update_strobe at t+12 relative to the end pulse.
- Break-before-make: old ser=1010101, new ser=0110011 -> BREAK shows 0010001 for exactly 8 cycles, then 0110011 with a one-cycle strobe.
- Identical LUT output on consecutive windows: -> no BREAK, no strobe, outputs unchanged.
- Sync period 10 clks (W=500 < N_MIN): -> locked=0, n_clk_cnts and bank states hold.
- Sync removed: -> locked=0 when cnt reaches 5001; FSM in IDLE; banks hold. Sync reapplied at period 30 -> n_clk_cnts=1500 and locked=1 after a full window.
- Frequency sweep 40 kHz to 300 kHz and back with the lut_n LOOKUP_ID=1 and LOOKUP_ID=2 instances attached: -> every output transition is preceded by a DEAD_CLKS AND-interval; overrun stays 0.
